// File: rtl/pmesh_mask_pkg.sv
// pmesh_mask_pkg: P-Mesh mask constants and legality helper shared by splitter and merger.
package pmesh_mask_pkg;
  localparam logic [7:0] BASE_1B = 8'h01;
  localparam logic [7:0] BASE_2B = 8'h03;
  localparam logic [7:0] BASE_4B = 8'h0F;
  localparam logic [7:0] BASE_8B = 8'hFF;
  localparam int N_LEGAL = 15;
  localparam logic [7:0] LEGAL_MASKS [N_LEGAL] = '{
    BASE_8B,
    BASE_4B, BASE_4B << 4,
    BASE_2B, BASE_2B << 2, BASE_2B << 4, BASE_2B << 6,
    BASE_1B, BASE_1B << 1, BASE_1B << 2, BASE_1B << 3,
    BASE_1B << 4, BASE_1B << 5, BASE_1B << 6, BASE_1B << 7
  };
  typedef enum logic {EMPTY, FULL} state_t;
  // An all-zero mask is only a flush marker, so it needs last to be legal.
  function automatic logic is_legal_mask(input logic [7:0] mask, input logic last);
    is_legal_mask = (mask == 8'h00) & last;
    for (int i = 0; i < N_LEGAL; i++) is_legal_mask |= (mask == LEGAL_MASKS[i]);
  endfunction
endpackage

// File: rtl/pmesh_mask_check.sv
// pmesh_mask_check: alignment and overlap check of one fragment against the beat being built.
module pmesh_mask_check
  import pmesh_mask_pkg::*;
(
  input  logic [7:0] mask,
  input  logic       last,
  input  logic [7:0] acc_strb,
  output logic       legal,
  output logic       overlap,
  output logic       good
);
  assign legal   = is_legal_mask(mask, last);
  assign overlap = |(mask & acc_strb);
  assign good    = legal & ~overlap;
endmodule

// File: rtl/pmesh_mask_merge.sv
// pmesh_mask_merge: merges aligned P-Mesh fragments back into one AXI-style strobed beat.
module pmesh_mask_merge
  import pmesh_mask_pkg::*;
#(
  parameter int STRB_W = 8,
  parameter int DATA_W = 8 * STRB_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [STRB_W-1:0] s_mask,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [STRB_W-1:0] m_strb,
  output logic [DATA_W-1:0] m_data,
  output logic [3:0]        m_frags,
  output logic              m_err
);
  state_t            state;
  logic [STRB_W-1:0] acc_strb, nxt_strb;
  logic [DATA_W-1:0] acc_data, nxt_data;
  logic [3:0]        acc_cnt, nxt_cnt;
  logic              acc_err;
  logic              legal, overlap, good, s_fire;

  pmesh_mask_check u_check (
    .mask    (s_mask),
    .last    (s_last),
    .acc_strb(acc_strb),
    .legal   (legal),
    .overlap (overlap),
    .good    (good)
  );

  assign m_valid = (state == FULL);
  assign s_ready = ~m_valid | m_ready;
  assign s_fire  = s_valid & s_ready;

  always_comb begin
    nxt_strb = good ? (acc_strb | s_mask) : acc_strb;
    nxt_cnt  = (&acc_cnt) ? acc_cnt : acc_cnt + 4'd1;
    nxt_data = acc_data;
    for (int i = 0; i < STRB_W; i++)
      if (good && s_mask[i]) nxt_data[8*i +: 8] = s_data[8*i +: 8];
  end

  // A last-accept moves the merged result to the output and restarts the accumulator in one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      acc_strb <= '0;
      acc_data <= '0;
      acc_cnt  <= '0;
      acc_err  <= 1'b0;
      m_strb   <= '0;
      m_data   <= '0;
      m_frags  <= '0;
      m_err    <= 1'b0;
    end else begin
      if (s_fire && s_last) begin
        state    <= FULL;
        m_strb   <= nxt_strb;
        m_data   <= nxt_data;
        m_frags  <= nxt_cnt;
        m_err    <= acc_err | ~good;
        acc_strb <= '0;
        acc_data <= '0;
        acc_cnt  <= '0;
        acc_err  <= 1'b0;
      end else begin
        if (s_fire) begin
          acc_strb <= nxt_strb;
          acc_data <= nxt_data;
          acc_cnt  <= nxt_cnt;
          acc_err  <= acc_err | ~good;
        end
        if (state == FULL && m_ready) state <= EMPTY;
      end
    end
  end
endmodule
